pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the ports below; clk and rst come first.
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_stall  in  1  data memory busy; freezes the pipeline
- ex_br_taken  in  1  branch/jump in EX resolved taken
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  3  load destination register in EX
- id_rs, id_rt  in  3 each  source registers of the instruction in D
- id_rs_used, id_rt_used  in  1 each  source actually read
- id_halt  in  1  instruction in D is HALT
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register write enables
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP into D/EX (halt, mem_writeEn, regwrite cleared)
- halted  out  1  processor halted
- state  out  2  FSM state (debug)
- stall_cnt  out  16  saturating count of frozen-fetch cycles

Function
REQ-002 SHALL implement the states RUN=0, DRAIN=1 and HALTED=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-003 SHALL define the load-use condition lu = ex_memread & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-004 SHALL decode stage controls combinationally from state and inputs, in this priority order (highest first):
- mem_stall (any state except HALTED): all five enables 0; ifid_flush 0; idex_bubble 0; no state or counter change.
- RUN with ex_br_taken: pc_en 1; ifid_flush 1; idex_bubble 1; other enables 1.
- RUN with lu: pc_en 0; ifid_en 0; idex_en 1 with idex_bubble 1; exmem_en and memwb_en 1.
- RUN with id_halt: pc_en 0; ifid_flush 1; idex_en 1 with no bubble, so HALT enters D/EX; next state DRAIN; drain counter loaded with 2.
- RUN otherwise: all enables 1; ifid_flush 0; idex_bubble 0.
REQ-005 SHALL make ex_br_taken override lu and id_halt in the same cycle, so the younger HALT is flushed and no DRAIN entry occurs.
REQ-006 SHALL ignore id_halt in any cycle where lu is 1; HALT is accepted in the cycle after the bubble.
REQ-007 SHALL drive the following in DRAIN: pc_en 0, ifid_en 0, idex_en 1 with idex_bubble 1, exmem_en 1, memwb_en 1; ex_br_taken, lu and id_halt are ignored.
REQ-008 SHALL decrement the 2-bit drain counter on each non-mem_stall DRAIN cycle; DRAIN lasts exactly 3 unstalled cycles (counter values 2, 1, 0); at counter 0 without mem_stall, next state SHALL be HALTED.
REQ-009 SHALL in HALTED drive all enables 0 and both flush/bubble outputs 0, hold halted=1, ignore all inputs including mem_stall, and leave HALTED only via reset.
REQ-010 SHALL drive halted=1 only in HALTED, registered (asserted the cycle after the last DRAIN cycle).
REQ-011 SHALL increment stall_cnt by 1 on each rising edge where pc_en=0 and state is not HALTED; it saturates at 16'hFFFF with no wrap.
REQ-012 SHALL keep ex_br_taken asserted during mem_stall pending; it takes effect in the first unstalled cycle with no lost flush.

Reset
REQ-013 SHALL, while rst=0 and asynchronously to clk: state=RUN, drain counter=0, stall_cnt=0, halted=0.
REQ-014 SHALL, while rst=0, hold all enables 0 and ifid_flush/idex_bubble 0; after rst rises, the first clk edge operates from RUN.
REQ-015 SHALL, on reset asserted in DRAIN or HALTED, abandon the drain immediately with no residual halted pulse.

Verification
REQ-016 SHALL be covered by a bench exercising at least these scenarios:
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_used=1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt 0->1; normal the next cycle.
- Branch plus load-use plus halt in one cycle -> ifid_flush=1, idex_bubble=1, pc_en=1; state stays RUN.
- HALT in D -> accept cycle, 3 DRAIN cycles, then halted=1 on cycle 5; stall_cnt=4.
- mem_stall for 2 cycles mid-DRAIN -> all enables 0; counter frozen; HALTED reached 2 cycles late.
- rst pulled low asynchronously while HALTED -> state=0, halted=0, stall_cnt=0 without a clk edge.
- 65540 forced load-use cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/halt controller: stage enables, flush/bubble decode, halt drain
// sequencing and a saturating frozen-fetch counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic        ex_br_taken,
  input  logic        ex_memread,
  input  logic [2:0]  ex_rd,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  // state   | meaning
  // RUN     | normal issue, hazards resolved by flush/bubble
  // DRAIN   | HALT travelling down the pipe, bubbles behind it
  // HALTED  | pipe frozen until reset
  // ILLEGAL | unreachable encoding, recovers to RUN
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] stall_q, stall_d;
  logic        halted_q;
  logic        lu;

  assign lu = ex_memread & ((id_rs_used & (id_rs == ex_rd)) |
                            (id_rt_used & (id_rt == ex_rd)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            // hold everything; a pending branch is re-evaluated once unstalled
          end else if (ex_br_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end else if (id_halt) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            state_d    = DRAIN;
            drain_d    = 2'd2;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            if (drain_q == 2'd0) state_d = HALTED;
            else                 drain_d = drain_q - 2'd1;
          end
        end
        HALTED: begin
        end
        default: begin
          state_d = RUN;
          drain_d = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (state_q != HALTED) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      drain_q  <= 2'd0;
      stall_q  <= 16'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted    = halted_q;
  assign state     = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle decode table from RUN plus
// hand-written drain, stall, reset and saturation sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_stall = 1'b0, ex_br_taken = 1'b0, ex_memread = 1'b0;
  logic [2:0]  ex_rd = 3'd0, id_rs = 3'd0, id_rt = 3'd0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_halt = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_br_taken(ex_br_taken),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_halt(id_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ms, br, mr;
    logic [2:0] rd, rs, rt;
    logic       rsu, rtu, halt;
    logic [4:0] en;
    logic       fl, bb;
    logic [1:0] ns;
    logic [15:0] nc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  task automatic clear_inputs();
    mem_stall = 1'b0; ex_br_taken = 1'b0; ex_memread = 1'b0;
    ex_rd = 3'd0; id_rs = 3'd0; id_rt = 3'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
  endtask

  initial begin
    //           ms    br    mr    rd    rs    rt    rsu   rtu   halt  en        fl    bb    ns     nc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 5'b00111, 1'b0, 1'b1, 2'd0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 2'd0, 16'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd1, 1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b1, 1'b1, 2'd0, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b1, 2'd0, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 5'b00111, 1'b0, 1'b1, 2'd0, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'b01111, 1'b1, 1'b0, 2'd1, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 2'd0, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 2'd0, 16'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 2'd0, 16'd1};

    // outputs forced quiet while reset is held, even with RUN-normal inputs
    #3;
    chk("rst_en", {27'd0, ens()}, 32'd0);
    chk("rst_flush_bubble", {30'd0, ifid_flush, idex_bubble}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_halted_cnt", {15'd0, halted, stall_cnt}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      mem_stall = vecs[i].ms; ex_br_taken = vecs[i].br; ex_memread = vecs[i].mr;
      ex_rd = vecs[i].rd; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rs_used = vecs[i].rsu; id_rt_used = vecs[i].rtu; id_halt = vecs[i].halt;
      #1;
      chk($sformatf("v%0d_en", i), {27'd0, ens()}, {27'd0, vecs[i].en});
      chk($sformatf("v%0d_flush", i), {31'd0, ifid_flush}, {31'd0, vecs[i].fl});
      chk($sformatf("v%0d_bubble", i), {31'd0, idex_bubble}, {31'd0, vecs[i].bb});
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].ns});
      chk($sformatf("v%0d_stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].nc});
    end

    // HALT accept, three DRAIN cycles (branch/lu ignored), halted on cycle 5
    do_reset();
    id_halt = 1'b1;
    #1;
    chk("halt_accept_en", {27'd0, ens()}, 32'b01111);
    chk("halt_accept_flush", {31'd0, ifid_flush}, 32'd1);
    @(posedge clk); #1;
    chk("halt_enter_drain", {30'd0, state}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_br_taken = (i == 1);
      set_lu();
      #1;
      chk($sformatf("drain%0d_en", i), {27'd0, ens()}, 32'b00111);
      chk($sformatf("drain%0d_fb", i), {30'd0, ifid_flush, idex_bubble}, 32'b01);
      @(posedge clk); #1;
      chk($sformatf("drain%0d_state", i), {30'd0, state}, (i < 2) ? 32'd1 : 32'd2);
      chk($sformatf("drain%0d_halted", i), {31'd0, halted}, (i < 2) ? 32'd0 : 32'd1);
    end
    chk("halt_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    @(negedge clk);
    mem_stall = 1'b1; ex_br_taken = 1'b1; id_halt = 1'b1;
    #1;
    chk("halted_en", {27'd0, ens()}, 32'd0);
    chk("halted_fb", {30'd0, ifid_flush, idex_bubble}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("halted_hold", {13'd0, state, halted, stall_cnt}, {13'd0, 2'd2, 1'b1, 16'd4});

    // asynchronous reset while HALTED, sampled before any clock edge
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {13'd0, state, halted, stall_cnt}, 32'd0);
    chk("async_rst_en", {27'd0, ens()}, 32'd0);

    // two mem_stall cycles after the first DRAIN cycle delay HALTED by two
    do_reset();
    id_halt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    id_halt = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_stall = 1'b1;
      #1;
      chk($sformatf("ms_drain%0d_en", i), {29'd0, ens(), ifid_flush, idex_bubble} >> 2, 32'd0);
      chk($sformatf("ms_drain%0d_bubble", i), {31'd0, idex_bubble}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("ms_drain%0d_state", i), {30'd0, state}, 32'd1);
    end
    @(negedge clk);
    mem_stall = 1'b0;
    @(posedge clk); #1;
    chk("ms_drain_resume", {30'd0, state}, 32'd1);
    @(posedge clk); #1;
    chk("ms_drain_halted", {29'd0, state, halted}, {29'd0, 2'd2, 1'b1});
    chk("ms_drain_stall_cnt", {16'd0, stall_cnt}, 32'd6);

    // branch held through mem_stall takes effect on the first free cycle
    do_reset();
    mem_stall = 1'b1; ex_br_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("br_pend%0d_flush", i), {31'd0, ifid_flush}, 32'd0);
      @(negedge clk);
    end
    mem_stall = 1'b0;
    #1;
    chk("br_release", {29'd0, pc_en, ifid_flush, idex_bubble}, 32'b111);

    // HALT ignored during load-use, accepted the cycle after the bubble
    do_reset();
    set_lu();
    id_halt = 1'b1;
    #1;
    chk("lu_halt_bubble", {30'd0, pc_en, idex_bubble}, 32'b01);
    @(posedge clk); #1;
    chk("lu_halt_state_run", {30'd0, state}, 32'd0);
    @(negedge clk);
    ex_memread = 1'b0;
    #1;
    chk("lu_halt_accept", {30'd0, pc_en, ifid_flush}, 32'b01);
    @(posedge clk); #1;
    chk("lu_halt_drain", {30'd0, state}, 32'd1);

    // saturation of stall_cnt under continuous load-use
    do_reset();
    set_lu();
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    @(posedge clk); #1;
    chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
